// File: rtl/baud_tick_gen.sv
// Runtime-programmable baud tick generator.
// A prescaler divides clk by an effective divisor to give os_tick. An
// oversample counter turns os_tick into bit_tick (bit boundary) and
// half_tick (mid-bit sample point). A new divisor is staged in a pending
// register. It takes effect only at a prescaler wrap, or while the
// counters are held, so a running tick period is never cut short.
module baud_tick_gen #(
  parameter int CNT_W   = 16,
  parameter int OVS     = 16,
  parameter int DEF_DIV = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             restart,
  input  logic             half_mode,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_in,
  output logic [CNT_W-1:0] div_q,
  output logic             div_pend,
  output logic             div_ack,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             half_tick
);

  localparam int               OS_W      = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  // Prescaler / oversample state
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             half_tick_q, half_tick_d;

  // Divisor state
  logic [CNT_W-1:0] div_val_q, div_val_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             div_pend_q, div_pend_d;
  logic             div_ack_q, div_ack_d;

  // Derived control
  logic [CNT_W-1:0] eff_raw;
  logic [CNT_W-1:0] eff;
  logic             run;
  logic             terminal;
  logic             apply_pt;
  logic             pend_any;
  logic [CNT_W-1:0] pend_src;

  // Effective terminal count. Divisors 0 and 1 both mean "tick every cycle".
  always_comb begin
    eff_raw = half_mode ? (div_val_q >> 1) : div_val_q;
    eff     = (eff_raw <= ONE) ? ONE : eff_raw;
  end

  assign run      = enb & ~restart;
  // ">=" also covers a count left above the new terminal value after the
  // divisor shrinks or half_mode switches on.
  assign terminal = (pre_cnt_q >= (eff - ONE));
  // A new divisor may be applied at a prescaler wrap or while counters are held.
  assign apply_pt = ~run | terminal;
  assign pend_any = div_wr | div_pend_q;
  // A write in the same cycle as the apply point wins over the older staged value.
  assign pend_src = div_wr ? div_in : pend_val_q;

  // Next-state for the prescaler, oversample counter and tick outputs
  always_comb begin
    pre_cnt_d   = pre_cnt_q;
    os_cnt_d    = os_cnt_q;
    os_tick_d   = 1'b0;
    bit_tick_d  = 1'b0;
    half_tick_d = 1'b0;
    if (!run) begin
      pre_cnt_d = '0;
      os_cnt_d  = '0;
    end else if (terminal) begin
      pre_cnt_d   = '0;
      os_cnt_d    = os_cnt_q + OS_W'(1);
      os_tick_d   = 1'b1;
      bit_tick_d  = (os_cnt_q == OS_LAST);
      half_tick_d = (os_cnt_q == OS_MID);
    end else begin
      pre_cnt_d = pre_cnt_q + ONE;
    end
  end

  // Next-state for the divisor staging and apply handshake
  always_comb begin
    div_val_d  = div_val_q;
    pend_val_d = pend_val_q;
    div_pend_d = div_pend_q;
    div_ack_d  = 1'b0;
    if (apply_pt && pend_any) begin
      div_val_d  = pend_src;
      div_pend_d = 1'b0;
      div_ack_d  = 1'b1;
    end else if (div_wr) begin
      pend_val_d = div_in;
      div_pend_d = 1'b1;
    end
  end

  // Register counters and ticks; reset clears them immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_q   <= '0;
      os_cnt_q    <= '0;
      os_tick_q   <= 1'b0;
      bit_tick_q  <= 1'b0;
      half_tick_q <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      os_cnt_q    <= os_cnt_d;
      os_tick_q   <= os_tick_d;
      bit_tick_q  <= bit_tick_d;
      half_tick_q <= half_tick_d;
    end
  end

  // Register divisor state; reset drops any staged divisor
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_val_q  <= DEF_DIV_C;
      pend_val_q <= '0;
      div_pend_q <= 1'b0;
      div_ack_q  <= 1'b0;
    end else begin
      div_val_q  <= div_val_d;
      pend_val_q <= pend_val_d;
      div_pend_q <= div_pend_d;
      div_ack_q  <= div_ack_d;
    end
  end

  assign div_q     = div_val_q;
  assign div_pend  = div_pend_q;
  assign div_ack   = div_ack_q;
  assign os_tick   = os_tick_q;
  assign bit_tick  = bit_tick_q;
  assign half_tick = half_tick_q;

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
Runtime-programmable baud tick generator for the UART TX/RX paths. It replaces fixed-count clock enables with three outputs: a divisor-based oversample tick, a bit tick and a mid-bit tick. The divisor is written over a simple write/ack interface and applied glitch-free at a tick boundary. It also supports a half-divisor fast mode and a synchronous restart, so RX can realign to a start-bit edge.

Parameters:
CNT_W, 16, width of the divisor and of the prescaler counter
OVS, 16, oversample factor; power of 2, minimum 2
DEF_DIV, 27, divisor loaded at reset; must fit in CNT_W

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous active-low reset
enb  input  1  run enable; low holds counters and ticks cleared
restart  input  1  synchronous one-cycle realign; clears counters, priority over enb
half_mode  input  1  1 = effective divisor is div_q>>1
div_wr  input  1  divisor write strobe
div_in  input  CNT_W  divisor value for div_wr
div_q  output  CNT_W  currently applied divisor
div_pend  output  1  a written divisor is waiting to be applied
div_ack  output  1  one-cycle pulse in the cycle after a divisor is applied
os_tick  output  1  oversample tick, one cycle wide
bit_tick  output  1  one tick per OVS os_ticks (bit boundary)
half_tick  output  1  tick at os_cnt==OVS/2-1 (mid-bit sample)

Behaviour:
- Reset (rst low, async): div_q=DEF_DIV, pend register=0, div_pend=0, pre_cnt=0, os_cnt=0; os_tick, bit_tick, half_tick and div_ack all 0.
- Effective terminal count:
  - eff = half_mode ? div_q>>1 : div_q.
  - If eff is 0 or 1, it is forced to 1, giving an os_tick every enabled cycle.
  - half_mode is sampled every cycle; a change takes effect on the next compare.
- Per enabled clock (enb=1, restart=0):
  - If pre_cnt==eff-1: pre_cnt<=0, os_tick<=1, os_cnt<=os_cnt+1 (wraps modulo OVS).
  - Otherwise: pre_cnt<=pre_cnt+1, os_tick<=0.
- bit_tick and half_tick are registered in the same cycle as os_tick:
  - bit_tick<=1 when wrapping from os_cnt==OVS-1.
  - half_tick<=1 when leaving os_cnt==OVS/2-1.
- All ticks are registered outputs. First os_tick is high in the cycle after the eff-th enabled edge. Period is exactly eff cycles; bit_tick period is eff*OVS.
- If pre_cnt>=eff-1 (possible after the divisor shrinks or half_mode toggles), it is treated as terminal: wrap to 0 and tick.
- enb=0: pre_cnt and os_cnt <=0; all ticks <=0.
- restart=1: same clear as enb=0 regardless of enb. The next enabled cycle counts from 0, so half_tick lands eff*(OVS/2) cycles after restart is released.
- Divisor update:
  - div_wr captures div_in into the pend register and sets div_pend=1.
  - A second div_wr while pending overwrites the captured value; only one div_ack results.
  - Apply point is the first cycle where the prescaler wraps (terminal), or any cycle where enb=0 or restart=1.
  - At the apply point: div_q<=pending value, div_pend<=0, div_ack<=1 for one cycle.
  - If div_wr coincides with an apply point, div_in itself is applied that cycle.
  - Writing 0 is legal and behaves as divisor 1.
- Counter width is CNT_W, with no overflow; os_cnt width is log2(OVS).
- Reset mid-operation aborts a pending divisor; div_q returns to DEF_DIV.

Test Plan:
1. DEF_DIV=4, OVS=4, enb=1 from reset -> os_tick every 4 cycles, first on cycle 5; half_tick on the 2nd os_tick; bit_tick on the 4th, every 16 cycles.
2. half_mode=1 with div_q=4 -> os_tick every 2 cycles. half_mode=1 with div_q=1 -> os_tick every cycle.
3. Write div_in=6 when pre_cnt=1 (div 4) -> div_pend=1 until the next wrap; div_ack 1 cycle later; div_q=6; subsequent os_tick spacing is 6. Write 6 then 8 before the wrap -> div_q=8, single div_ack.
4. restart pulse mid-bit -> next half_tick exactly eff*OVS/2 = 8 cycles (div 4, OVS 4) after restart deasserts; bit_tick after 16.
5. enb dropped for 3 cycles with a write pending -> ticks 0, counters 0, divisor applied immediately with div_ack; on re-enable the first tick follows the new spacing.
6. Async reset asserted mid-count with div_pend=1 -> all outputs 0, div_q=DEF_DIV, div_pend=0 immediately, without waiting for a clock edge.
